// File: rtl/load_store_unit_if.sv
// Word-wide memory port between the load/store unit (master) and the unified memory (slave).
// readData is combinational from memAdr; the memory writes on the rising edge when memWrite is high.
interface load_store_unit_if #(
   parameter int ADDR_W = 32
) ();

   logic [ADDR_W-1:0] memAdr;
   logic [31:0]       writeData;
   logic              memWrite;
   logic [31:0]       readData;

   modport master (
      output memAdr,
      output writeData,
      output memWrite,
      input  readData
   );

   modport slave (
      input  memAdr,
      input  writeData,
      input  memWrite,
      output readData
   );

endinterface

// File: rtl/load_store_unit.sv
// Byte/halfword/word load-store initiator on a single word-wide memory port; sub-word stores
// are read-modify-write. Define LSU_MISALIGN_TRAP_EN to flag misaligned requests instead of masking them.
module load_store_unit #(
   parameter int          ADDR_W   = 32,
   parameter logic [31:0] RST_LOAD = 32'h0000_0000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              isStore,
   input  logic [2:0]        funct3,
   input  logic [ADDR_W-1:0] adr,
   input  logic [31:0]       storeData,
   output logic              busy,
   output logic              done,
   output logic [31:0]       loadData,
   output logic              misaligned,
   load_store_unit_if.master mem
);

   typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} stateT;

   stateT             stateReg;
   stateT             stateNext;
   logic [ADDR_W-1:0] adrReg;
   logic [2:0]        funct3Reg;
   logic              isStoreReg;
   logic [31:0]       storeDataReg;
   logic [31:0]       bufReg;
   logic [31:0]       loadDataReg;

   logic              accept;
   logic              reqMisaligned;
   logic              wordAcc;
   logic              halfAcc;
   logic              signedLoad;
   logic [7:0]        readLane [4];
   logic [7:0]        byteSel;
   logic [15:0]       halfSel;
   logic [31:0]       mergedWord;
   logic [31:0]       extractedWord;

   assign accept     = (stateReg == IDLE) && start;
   // funct3[1] set means word access for both loads and stores (covers 010/011/110/111)
   assign wordAcc    = funct3Reg[1];
   assign halfAcc    = (funct3Reg[1:0] == 2'b01);
   assign signedLoad = ~funct3Reg[2];

`ifdef LSU_MISALIGN_TRAP_EN
   logic misalignedReg;

   assign reqMisaligned = funct3[1] ? (adr[1:0] != 2'b00)
                                    : ((funct3[1:0] == 2'b01) && adr[0]);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         misalignedReg <= 1'b0;
      end else if (accept) begin
         misalignedReg <= reqMisaligned;
      end
   end

   assign misaligned = (stateReg == DONE) && misalignedReg;
`else
   assign reqMisaligned = 1'b0;
   assign misaligned    = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stateReg <= IDLE;
      end else begin
         stateReg <= stateNext;
      end
   end

   always_comb begin
      stateNext    = stateReg;
      busy         = 1'b1;
      done         = 1'b0;
      mem.memWrite = 1'b0;
      case (stateReg)
         IDLE: begin
            busy = 1'b0;
            if (start) begin
               if (reqMisaligned) begin
                  stateNext = DONE;
               end else if (isStore && funct3[1]) begin
                  stateNext = WRITE;
               end else begin
                  stateNext = READ;
               end
            end
         end
         READ: begin
            stateNext = isStoreReg ? WRITE : DONE;
         end
         WRITE: begin
            mem.memWrite = 1'b1;
            stateNext    = DONE;
         end
         DONE: begin
            done      = 1'b1;
            stateNext = IDLE;
         end
         default: begin
            stateNext = IDLE;
         end
      endcase
   end

   // Request fields are frozen at acceptance; the READ cycle fills either loadData or the RMW buffer
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         adrReg       <= '0;
         funct3Reg    <= '0;
         isStoreReg   <= 1'b0;
         storeDataReg <= '0;
         bufReg       <= '0;
         loadDataReg  <= RST_LOAD;
      end else begin
         if (accept) begin
            adrReg       <= adr;
            funct3Reg    <= funct3;
            isStoreReg   <= isStore;
            storeDataReg <= storeData;
         end
         if (stateReg == READ) begin
            if (isStoreReg) begin
               bufReg <= mem.readData;
            end else begin
               loadDataReg <= extractedWord;
            end
         end
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : gLane
         localparam logic [1:0] LANE = 2'(gi);
         logic       laneEn;
         logic [7:0] laneSrc;

         assign readLane[gi] = mem.readData[8*gi +: 8];

         assign laneEn  = wordAcc
                       || (halfAcc && (adrReg[1] == LANE[1]))
                       || (!wordAcc && !halfAcc && (adrReg[1:0] == LANE));
         assign laneSrc = wordAcc ? storeDataReg[8*gi +: 8]
                        : halfAcc ? storeDataReg[8*(gi%2) +: 8]
                        : storeDataReg[7:0];

         assign mergedWord[8*gi +: 8] = laneEn ? laneSrc : bufReg[8*gi +: 8];
      end
   endgenerate

   assign byteSel = readLane[adrReg[1:0]];
   assign halfSel = adrReg[1] ? mem.readData[31:16] : mem.readData[15:0];

   always_comb begin
      if (wordAcc) begin
         extractedWord = mem.readData;
      end else if (halfAcc) begin
         extractedWord = {{16{signedLoad & halfSel[15]}}, halfSel};
      end else begin
         extractedWord = {{24{signedLoad & byteSel[7]}}, byteSel};
      end
   end

   assign mem.memAdr    = ((stateReg == READ) || (stateReg == WRITE))
                        ? {adrReg[ADDR_W-1:2], 2'b00} : '0;
   assign mem.writeData = (stateReg == WRITE) ? mergedWord : '0;
   assign loadData      = loadDataReg;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed vector table, multi-cycle corner sequences and random
// traffic checked against a byte-addressed reference memory.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        isStore;
   logic [2:0]  funct3;
   logic [31:0] adr;
   logic [31:0] storeData;
   logic        busy;
   logic        done;
   logic [31:0] loadData;
   logic        misaligned;

   load_store_unit_if #(.ADDR_W(32)) memIf ();

   load_store_unit dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .isStore    (isStore),
      .funct3     (funct3),
      .adr        (adr),
      .storeData  (storeData),
      .busy       (busy),
      .done       (done),
      .loadData   (loadData),
      .misaligned (misaligned),
      .mem        (memIf)
   );

   always #5 clk = ~clk;

   // Bench-side memory seen by the DUT (1 KiB, word organised)
   logic [31:0] memWords [0:255];
   assign memIf.readData = memWords[memIf.memAdr[9:2]];

   initial begin
      for (int i = 0; i < 256; i++) begin
         memWords[i] = $urandom;
      end
      memWords[32'h100 >> 2] = 32'h8899AABB;
      forever begin
         @(posedge clk);
         if (memIf.memWrite) begin
            memWords[memIf.memAdr[9:2]] = memIf.writeData;
         end
      end
   end

   // Reference model: plain byte array plus the expected loadData value
   logic [7:0]  refBytes [0:1023];
   logic [31:0] expLoad;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic int accSize(input logic [2:0] f3);
      return f3[1] ? 4 : (f3[0] ? 2 : 1);
   endfunction

   function automatic logic [31:0] refWordAt(input logic [31:0] a);
      int off;
      int base;
      off  = int'(a % 1024);
      base = off - (off % 4);
      return {refBytes[base+3], refBytes[base+2], refBytes[base+1], refBytes[base]};
   endfunction

   task automatic refApply(input logic st, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] sd, output int lat, output int wr,
                           output logic mis);
      int     sz;
      int     off;
      int     base;
      longint val;
      sz   = accSize(f3);
      off  = int'(a % 1024);
      base = off - (off % sz);
      val  = 0;
`ifdef LSU_MISALIGN_TRAP_EN
      mis = ((off % sz) != 0);
`else
      mis = 1'b0;
`endif
      if (mis) begin
         lat = 1;
         wr  = 0;
      end else if (st) begin
         for (int i = 0; i < sz; i++) begin
            refBytes[base+i] = 8'(sd >> (8*i));
         end
         lat = (sz == 4) ? 2 : 3;
         wr  = 1;
      end else begin
         for (int i = 0; i < sz; i++) begin
            val += longint'(refBytes[base+i]) << (8*i);
         end
         if (!f3[2] && (sz < 4) && (val >= (longint'(1) << (8*sz-1)))) begin
            val -= longint'(1) << (8*sz);
         end
         expLoad = 32'(val);
         lat     = 2;
         wr      = 0;
      end
   endtask

   // Issue one request; report done latency (cycles after the start edge), memWrite cycles, misaligned
   task automatic runOp(input logic st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] sd, output int lat, output int wr, output logic mis);
      @(negedge clk);
      start     = 1'b1;
      isStore   = st;
      funct3    = f3;
      adr       = a;
      storeData = sd;
      @(posedge clk);
      #1;
      start     = 1'b0;
      adr       = $urandom;
      storeData = $urandom;
      lat = -1;
      wr  = 0;
      mis = 1'b0;
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         if (memIf.memWrite) wr++;
         if (done) begin
            lat = c;
            mis = misaligned;
            break;
         end
      end
   endtask

   typedef struct {
      logic        st;
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] sd;
      logic [31:0] expLoad;
      int          expLat;
      logic [31:0] expWord;
   } vecT;

   localparam int NV = 14;
   vecT vecs [NV];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int   lat, wr, eLat, eWr, extra;
      logic mis, eMis;
      logic [31:0] prevWord;

      vecs[0]  = '{1'b0, 3'b000, 32'h102, 32'h0,        32'hFFFFFF99, 2, 32'h8899AABB};
      vecs[1]  = '{1'b0, 3'b100, 32'h103, 32'h0,        32'h00000088, 2, 32'h8899AABB};
      vecs[2]  = '{1'b0, 3'b101, 32'h102, 32'h0,        32'h00008899, 2, 32'h8899AABB};
      vecs[3]  = '{1'b0, 3'b001, 32'h100, 32'h0,        32'hFFFFAABB, 2, 32'h8899AABB};
      vecs[4]  = '{1'b0, 3'b010, 32'h100, 32'h0,        32'h8899AABB, 2, 32'h8899AABB};
      vecs[5]  = '{1'b0, 3'b000, 32'h100, 32'h0,        32'hFFFFFFBB, 2, 32'h8899AABB};
      vecs[6]  = '{1'b1, 3'b000, 32'h101, 32'h12345677, 32'hFFFFFFBB, 3, 32'h889977BB};
      vecs[7]  = '{1'b1, 3'b001, 32'h102, 32'h0000CAFE, 32'hFFFFFFBB, 3, 32'hCAFE77BB};
      vecs[8]  = '{1'b1, 3'b010, 32'h200, 32'hDEADBEEF, 32'hFFFFFFBB, 2, 32'hDEADBEEF};
      vecs[9]  = '{1'b0, 3'b011, 32'h100, 32'h0,        32'hCAFE77BB, 2, 32'hCAFE77BB};
      vecs[10] = '{1'b0, 3'b001, 32'h202, 32'h0,        32'hFFFFDEAD, 2, 32'hDEADBEEF};
      vecs[11] = '{1'b0, 3'b100, 32'h201, 32'h0,        32'h000000BE, 2, 32'hDEADBEEF};
      vecs[12] = '{1'b1, 3'b111, 32'h204, 32'h01020304, 32'h000000BE, 2, 32'h01020304};
      vecs[13] = '{1'b0, 3'b101, 32'h206, 32'h0,        32'h00000102, 2, 32'h01020304};

      rst = 1'b0; start = 1'b0; isStore = 1'b0; funct3 = 3'b000; adr = '0; storeData = '0;
      expLoad = 32'h0;
      repeat (2) @(negedge clk);
      for (int i = 0; i < 1024; i++) begin
         refBytes[i] = memWords[i/4][8*(i%4) +: 8];
      end

      check("rst_busy",       32'(busy),             32'h0);
      check("rst_done",       32'(done),             32'h0);
      check("rst_misaligned", 32'(misaligned),       32'h0);
      check("rst_loadData",   loadData,              32'h0);
      check("rst_memAdr",     memIf.memAdr,          32'h0);
      check("rst_writeData",  memIf.writeData,       32'h0);
      check("rst_memWrite",   32'(memIf.memWrite),   32'h0);
      rst = 1'b1;

      for (int i = 0; i < NV; i++) begin
         runOp(vecs[i].st, vecs[i].f3, vecs[i].a, vecs[i].sd, lat, wr, mis);
         refApply(vecs[i].st, vecs[i].f3, vecs[i].a, vecs[i].sd, eLat, eWr, eMis);
         check($sformatf("tbl%0d_loadData", i), loadData, vecs[i].expLoad);
         check($sformatf("tbl%0d_latency", i), 32'(lat), 32'(vecs[i].expLat));
         check($sformatf("tbl%0d_memWrite", i), 32'(wr), vecs[i].st ? 32'h1 : 32'h0);
         check($sformatf("tbl%0d_misaligned", i), 32'(mis), 32'h0);
         check($sformatf("tbl%0d_word", i), memWords[vecs[i].a[9:2]], vecs[i].expWord);
         $display("tbl %0d: st=%0d f3=%b adr=%h sd=%h loadData=%h lat=%0d",
                  i, vecs[i].st, vecs[i].f3, vecs[i].a, vecs[i].sd, loadData, lat);
      end

      // start held high while busy must not launch a second access
      @(negedge clk);
      start = 1'b1; isStore = 1'b1; funct3 = 3'b010; adr = 32'h208; storeData = 32'h11111111;
      @(posedge clk);
      #1;
      adr = 32'h20C; storeData = 32'h22222222;
      @(posedge clk);
      #1;
      start = 1'b0;
      @(negedge clk);
      check("busy_start_done", 32'(done), 32'h1);
      refApply(1'b1, 3'b010, 32'h208, 32'h11111111, eLat, eWr, eMis);
      extra = 0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if (busy || done) extra++;
      end
      check("busy_start_ignored", 32'(extra), 32'h0);
      check("busy_start_word208", memWords[32'h208 >> 2], 32'h11111111);
      check("busy_start_word20C", memWords[32'h20C >> 2], refWordAt(32'h20C));
      $display("seq busy-start: sw 208 done, second start ignored");

      // misaligned word load
      runOp(1'b0, 3'b010, 32'h102, 32'h0, lat, wr, mis);
      refApply(1'b0, 3'b010, 32'h102, 32'h0, eLat, eWr, eMis);
`ifdef LSU_MISALIGN_TRAP_EN
      check("mis_lw_latency", 32'(lat), 32'h1);
      check("mis_lw_flag", 32'(mis), 32'h1);
      check("mis_lw_loadData", loadData, 32'h00000102);
`else
      check("mis_lw_latency", 32'(lat), 32'h2);
      check("mis_lw_flag", 32'(mis), 32'h0);
      check("mis_lw_loadData", loadData, 32'hCAFE77BB);
`endif
      check("mis_lw_memWrite", 32'(wr), 32'h0);
      $display("seq misaligned lw 102: loadData=%h lat=%0d misaligned=%0d", loadData, lat, mis);

      // reset asserted during READ of a sub-word store
      prevWord = refWordAt(32'h104);
      @(negedge clk);
      start = 1'b1; isStore = 1'b1; funct3 = 3'b001; adr = 32'h104; storeData = 32'h0000ABCD;
      @(posedge clk);
      #1;
      start = 1'b0;
      #1;
      rst = 1'b0;
      #1;
      check("rstmid_busy", 32'(busy), 32'h0);
      check("rstmid_memWrite", 32'(memIf.memWrite), 32'h0);
      check("rstmid_loadData", loadData, 32'h0);
      check("rstmid_memAdr", memIf.memAdr, 32'h0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      expLoad = 32'h0;
      check("rstmid_word104", memWords[32'h104 >> 2], prevWord);
      runOp(1'b0, 3'b010, 32'h100, 32'h0, lat, wr, mis);
      refApply(1'b0, 3'b010, 32'h100, 32'h0, eLat, eWr, eMis);
      check("rstmid_after_lw", loadData, 32'hCAFE77BB);
      check("rstmid_after_lat", 32'(lat), 32'h2);
      $display("seq reset-in-READ: sh 104 aborted, lw 100 -> %h", loadData);

      // reset asserted during WRITE of a word store
      prevWord = refWordAt(32'h108);
      @(negedge clk);
      start = 1'b1; isStore = 1'b1; funct3 = 3'b010; adr = 32'h108; storeData = ~prevWord;
      @(posedge clk);
      #1;
      start = 1'b0;
      #1;
      rst = 1'b0;
      #1;
      check("rstwr_memWrite", 32'(memIf.memWrite), 32'h0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      expLoad = 32'h0;
      check("rstwr_word108", memWords[32'h108 >> 2], prevWord);
      $display("seq reset-in-WRITE: sw 108 aborted");

      for (int n = 0; n < 300; n++) begin
         logic        st;
         logic [2:0]  f3;
         logic [31:0] a;
         logic [31:0] sd;
         st = 1'($urandom_range(0, 1));
         f3 = 3'($urandom_range(0, 7));
         a  = 32'($urandom_range(0, 1023));
         sd = $urandom;
         runOp(st, f3, a, sd, lat, wr, mis);
         refApply(st, f3, a, sd, eLat, eWr, eMis);
         check($sformatf("rnd%0d_latency", n), 32'(lat), 32'(eLat));
         check($sformatf("rnd%0d_memWrite", n), 32'(wr), 32'(eWr));
         check($sformatf("rnd%0d_misaligned", n), 32'(mis), 32'(eMis));
         check($sformatf("rnd%0d_loadData", n), loadData, expLoad);
         if (st) begin
            check($sformatf("rnd%0d_word", n), memWords[a[9:2]], refWordAt(a));
         end
         $display("rnd %0d: st=%0d f3=%b adr=%h sd=%h loadData=%h lat=%0d mis=%0d",
                  n, st, f3, a, sd, loadData, lat, mis);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
